// File: rtl/core_mem_pkg.sv
// Shared memory-stage types: access sizes,
// responder state encoding and latency counter width.
package core_mem_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam int MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_BUSY = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit memory word
// and right-aligned core data, plus misalignment flag.
module dmem_lane_align
  import core_mem_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misalign_o
);

  logic [31:0] sh;
  logic        is_b;
  logic        is_h;
  logic        is_w;

  assign sh   = rword_i >> {addr_lo_i, 3'b000};
  assign is_b = (size_i == MEM_SIZE_B);
  assign is_h = (size_i == MEM_SIZE_H);
  assign is_w = (size_i == MEM_SIZE_W);

  // Extract/extend load lane; replicate store lane and build enables
  always_comb begin
    rdata_o    = '0;
    wdata_o    = '0;
    be_o       = '0;
    misalign_o = 1'b0;
    unique case (1'b1)
      is_b: begin
        rdata_o = uns_i ? {24'h0, sh[7:0]}
                        : {{24{sh[7]}}, sh[7:0]};
        wdata_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      is_h: begin
        rdata_o = uns_i ? {16'h0, sh[15:0]}
                        : {{16{sh[15]}}, sh[15:0]};
        wdata_o    = {2{wdata_i[15:0]}};
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      is_w: begin
        rdata_o    = rword_i;
        wdata_o    = wdata_i;
        be_o       = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time,
// fixed latency, single-cycle response pulse.
module dmem_responder
  import core_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [MEM_LAT_W-1:0] CNT_INIT =
    MEM_LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  rsp_state_e           state_q, state_d;
  logic [MEM_LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 we_q;
  logic [1:0]           size_q;
  logic                 uns_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             in_resp;
  logic [31:0]      widx;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [31:0]      ld_data;
  logic [31:0]      st_data;
  logic [3:0]       st_be;
  logic             misalign;
  logic             err;

  assign req_ready = (state_q == RSP_IDLE)
                   | (state_q == RSP_RESP);
  assign accept    = req_valid & req_ready;
  assign in_resp   = (state_q == RSP_RESP);

  assign widx     = {2'b00, addr_q[31:2]};
  assign in_range = widx < 32'(DEPTH_WORDS);
  assign idx      = addr_q[IDX_W+1:2];
  assign rword    = in_range ? mem_q[idx] : '0;

  dmem_lane_align u_align (
    .rword_i    (rword),
    .wdata_i    (wdata_q),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .rdata_o    (ld_data),
    .wdata_o    (st_data),
    .be_o       (st_be),
    .misalign_o (misalign)
  );

  assign err = (size_q == 2'b11) | misalign | ~in_range;

  assign resp_valid = in_resp;
  assign resp_err   = in_resp & err;
  assign resp_rdata = (in_resp & ~err & ~we_q)
                    ? ld_data : '0;

  // State and wait-counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: accept in IDLE/RESP, count down in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RSP_BUSY: begin
        if (cnt_q == '0) state_d = RSP_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RSP_RESP;
          end else begin
            state_d = RSP_BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = RSP_IDLE;
        end
      end
    endcase
  end

  // Capture the request fields on acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
    end
  end

  // Commit a legal store on the edge leaving RESP
  always_ff @(posedge clock) begin
    if (!reset && in_resp && we_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: three responders (latency 2/1/3) against
// a byte-array reference model and a cycle scoreboard.
module tb_dmem_responder;
  import core_mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  typedef struct packed {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rv  [NI];
  logic        rdy [NI];
  logic        we  [NI];
  logic        uns [NI];
  logic        vld [NI];
  logic        er  [NI];
  logic [31:0] ra  [NI];
  logic [31:0] wd  [NI];
  logic [31:0] rd  [NI];
  logic [1:0]  sz  [NI];

  int lat [NI] = '{2, 1, 3};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (g == 0 ? 2 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clock        (clk),
      .reset        (rst),
      .req_valid    (rv[g]),
      .req_ready    (rdy[g]),
      .req_addr     (ra[g]),
      .req_wdata    (wd[g]),
      .req_we       (we[g]),
      .req_size     (sz[g]),
      .req_unsigned (uns[g]),
      .resp_valid   (vld[g]),
      .resp_rdata   (rd[g]),
      .resp_err     (er[g])
    );
  end

  logic [7:0]  mdl [NI][DEPTH*4];
  req_t        q [$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd;
  logic        last_er;
  logic [31:0] prior;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(logic w, logic [1:0] s,
                              logic u, logic [31:0] a,
                              logic [31:0] d);
    req_t r;
    r.w = w; r.s = s; r.u = u; r.a = a; r.d = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0)
      a = 32'(DEPTH * 4) + $urandom_range(0, 4095);
    else
      a = 32'($urandom_range(0, DEPTH * 4 - 1));
    return mk(1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  // Architectural effect of one request on the model
  task automatic model_resp(int i, req_t r,
                            output logic [31:0] erd,
                            output logic eer);
    int n;
    logic [31:0] v;
    n   = 1 << r.s;
    eer = (r.s == 2'b11)
       || (r.s == 2'b01 && r.a[0])
       || (r.s == 2'b10 && r.a[1:0] != 2'b00)
       || ((r.a >> 2) >= 32'(DEPTH));
    erd = '0;
    if (!eer) begin
      if (r.w) begin
        for (int k = 0; k < n; k++)
          mdl[i][int'(r.a) + k] = r.d[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++)
          v |= 32'(mdl[i][int'(r.a) + k]) << (8 * k);
        if (!r.u && n < 4 && v[8*n-1])
          v |= ~((32'd1 << (8 * n)) - 32'd1);
        erd = v;
      end
    end
  endtask

  task automatic drive(int i, req_t r);
    rv[i]  = 1'b1;
    we[i]  = r.w;
    sz[i]  = r.s;
    uns[i] = r.u;
    ra[i]  = r.a;
    wd[i]  = r.d;
  endtask

  task automatic idle(int i);
    rv[i]  = 1'b0;
    we[i]  = 1'($urandom);
    sz[i]  = 2'($urandom);
    uns[i] = 1'($urandom);
    ra[i]  = $urandom;
    wd[i]  = $urandom;
  endtask

  // Issue the queued requests to instance i, scoring
  // every cycle: ready, valid, data and error.
  task automatic run(int i, bit hold);
    bit          pend = 0;
    int          cnt  = 0;
    int          cyc  = 0;
    bit          evld, erdy, pres;
    req_t        cur;
    logic [31:0] erd;
    logic        eer;
    cur = '0;
    while ((q.size() > 0 || pend) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      evld = pend && cnt == 0;
      erdy = !pend || cnt == 0;
      chk($sformatf("vld%0d", i), 32'(vld[i]), 32'(evld));
      chk($sformatf("rdy%0d", i), 32'(rdy[i]), 32'(erdy));
      if (evld) begin
        model_resp(i, cur, erd, eer);
        chk($sformatf("rdata%0d a=%h", i, cur.a),
            rd[i], erd);
        chk($sformatf("err%0d a=%h", i, cur.a),
            32'(er[i]), 32'(eer));
        last_rd = rd[i];
        last_er = er[i];
      end else begin
        chk($sformatf("idle_rd%0d", i), rd[i], 32'h0);
        chk($sformatf("idle_er%0d", i), 32'(er[i]), 32'h0);
      end
      if (pend) begin
        if (cnt == 0) pend = 0;
        else          cnt--;
      end
      pres = q.size() > 0
          && (hold || $urandom_range(0, 2) != 0);
      if (pres) begin
        drive(i, q[0]);
        if (erdy) begin
          cur  = q.pop_front();
          pend = 1;
          cnt  = lat[i] - 1;
        end
      end else begin
        idle(i);
      end
    end
    idle(i);
    chk($sformatf("drain%0d", i),
        32'(q.size()) + 32'(pend), 32'h0);
  endtask

  task automatic one(int i, req_t r);
    q.push_back(r);
    run(i, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) idle(i);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_rdy", 32'(rdy[i]), 32'h1);
      chk("rst_vld", 32'(vld[i]), 32'h0);
      chk("rst_rd",  rd[i], 32'h0);
      chk("rst_er",  32'(er[i]), 32'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < DEPTH; w++)
        q.push_back(mk(1'b1, MEM_SIZE_W, 1'b0,
                       32'(w * 4), $urandom));
      run(i, 1'b1);
    end

    one(0, mk(1, MEM_SIZE_W, 0, 32'h10, 32'hDEADBEEF));
    chk("p1_st_err", 32'(last_er), 32'h0);
    one(0, mk(0, MEM_SIZE_W, 0, 32'h10, 32'h0));
    chk("p1_ld", last_rd, 32'hDEADBEEF);

    one(0, mk(1, MEM_SIZE_B, 0, 32'h11, 32'h80));
    one(0, mk(0, MEM_SIZE_B, 0, 32'h11, 32'h0));
    chk("p2_lbs", last_rd, 32'hFFFFFF80);
    one(0, mk(0, MEM_SIZE_B, 1, 32'h11, 32'h0));
    chk("p2_lbu", last_rd, 32'h00000080);
    one(0, mk(0, MEM_SIZE_W, 0, 32'h10, 32'h0));
    chk("p2_lw", last_rd, 32'hDEAD80EF);

    one(0, mk(0, MEM_SIZE_H, 0, 32'h13, 32'h0));
    chk("p3_lh_err", 32'(last_er), 32'h1);
    chk("p3_lh_rd", last_rd, 32'h0);
    one(0, mk(1, MEM_SIZE_W, 0, 32'h12, 32'h55555555));
    chk("p3_sw_err", 32'(last_er), 32'h1);
    one(0, mk(0, MEM_SIZE_W, 0, 32'h10, 32'h0));
    chk("p3_keep", last_rd, 32'hDEAD80EF);
    one(0, mk(0, 2'b11, 0, 32'h10, 32'h0));
    chk("p3_rsv_err", 32'(last_er), 32'h1);
    one(0, mk(0, MEM_SIZE_W, 0, 32'(DEPTH * 4), 32'h0));
    chk("p3_oor_err", 32'(last_er), 32'h1);

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) begin
        q.push_back(mk(1'($urandom_range(0, 1)),
                       MEM_SIZE_W, 0,
                       32'($urandom_range(0, 7) * 4),
                       $urandom));
      end
      run(i, 1'b1);
    end

    prior = {mdl[0][35], mdl[0][34], mdl[0][33], mdl[0][32]};
    @(negedge clk);
    drive(0, mk(1, MEM_SIZE_W, 0, 32'h20, 32'h12345678));
    chk("p5_acc_rdy", 32'(rdy[0]), 32'h1);
    @(posedge clk);
    #1 idle(0);
    @(negedge clk);
    chk("p5_busy_rdy", 32'(rdy[0]), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("p5_rst_rdy", 32'(rdy[0]), 32'h1);
    chk("p5_rst_vld", 32'(vld[0]), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("p5_no_resp", 32'(vld[0]), 32'h0);
    end
    one(0, mk(0, MEM_SIZE_W, 0, 32'h20, 32'h0));
    chk("p5_keep", last_rd, prior);

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 80; k++) q.push_back(rnd_req());
      run(i, 1'b0);
      for (int k = 0; k < 20; k++) q.push_back(rnd_req());
      run(i, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
